// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS instruction-fetch stage.
//   - fetch_state_t : fetch FSM states. S_FAULT is present only when
//                     FETCH_MISALIGN_TRAP_EN is defined.
//   - DEFAULT_RESET_PC : default program counter after reset.
//   - Bit-position constants for the instruction fields op, funct,
//     imm16 and target26.
//   - sext_imm16() : sign-extends a 16-bit immediate to 32 bits.
// Configuration macro: FETCH_MISALIGN_TRAP_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_FAULT = 2'd2
`endif
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: purely combinational next-PC selection for the fetch stage.
// Priority order: jr, then jump, then taken branch, then sequential.
// Ports:
//   pc_plus4  in  32  address of the current instruction plus 4
//   instr     in  32  current instruction word
//   branch    in  1   the current instruction is a conditional branch
//   ne        in  1   branch on not-equal; the zero test is inverted
//   jump      in  1   j/jal
//   jr        in  1   jr/jalr
//   zero      in  1   ALU zero flag
//   jr_target in  32  register-source target for jr/jalr
//   next_pc   out 32  selected next PC, not yet alignment-adjusted
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        ne,
  input  logic        jump,
  input  logic        jr,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_op;

  // The opcode field is decoded upstream, so this block never reads it.
  assign unused_op = ^instr[OP_MSB:OP_LSB];

  // For bne, ne inverts the zero test, so one XOR covers beq and bne.
  assign branch_taken  = branch & (zero ^ ne);
  assign branch_target = pc_plus4 + (sext_imm16(instr[IMM_MSB:IMM_LSB]) << 2);
  assign jump_target   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the MIPS core. This block owns the
// program counter. It fetches one instruction at a time using an imem
// request/acknowledge handshake. It holds the instruction until the datapath
// retires it, and then loads the next PC.
// Parameter: RESET_PC, the word-aligned PC loaded on reset.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   imem_req/imem_addr    fetch request and address (address is always pc)
//   imem_ack/imem_rdata   memory response and instruction word
//   instr_valid/instr     registered instruction for the current pc
//   pc/pc_plus4           current PC and PC+4, both registered
//   retire                the datapath has finished the current instruction
//   branch/ne/jump/jr     decoder redirect controls
//   zero                  ALU zero flag
//   jr_target             register target for jr/jalr
//   fetch_fault           misaligned-target trap
// Configuration macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned next PC traps into S_FAULT. When it is undefined, bits [1:0]
// of the next PC are forced to zero.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        ne,
  input  logic        jump,
  input  logic        jr,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic        fetch_fault
);

  fetch_state_t state, state_next;
  logic         load_instr;
  logic         load_pc;
  logic         fault_flag;
  logic [31:0]  next_pc_raw;
  logic [31:0]  next_pc;

  next_pc_sel u_next_pc_sel (
    .pc_plus4  (pc_plus4),
    .instr     (instr),
    .branch    (branch),
    .ne        (ne),
    .jump      (jump),
    .jr        (jr),
    .zero      (zero),
    .jr_target (jr_target),
    .next_pc   (next_pc_raw)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned target is kept in pc so that the trap handler can see it.
  assign next_pc = next_pc_raw;
`else
  assign next_pc = {next_pc_raw[31:2], 2'b00};
`endif

  assign imem_addr   = pc;
  assign fetch_fault = fault_flag;

  // The state register. Reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and Moore outputs. An ack outside S_REQ is ignored,
  // and so is a retire outside S_VALID.
  always_comb begin
    state_next  = state;
    load_instr  = 1'b0;
    load_pc     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault_flag  = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (retire) begin
          load_pc    = 1'b1;
          state_next = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            state_next = S_FAULT;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        fault_flag = 1'b1;
      end
`endif
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Datapath registers. pc_plus4 is registered together with pc, so it
  // changes only when pc changes and never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC + 32'd4;
      instr    <= 32'd0;
    end else begin
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (load_pc) begin
        pc       <= next_pc;
        pc_plus4 <= next_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. It drives directed and
// randomized fetch/retire sequences. Expected values come from a
// behavioural next-PC model. FETCH_MISALIGN_TRAP_EN selects the
// misalignment scenario that is checked.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire = 1'b0;
  logic        branch = 1'b0;
  logic        ne = 1'b0;
  logic        jump = 1'b0;
  logic        jr = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        fetch_fault;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .branch      (branch),
    .ne          (ne),
    .jump        (jump),
    .jr          (jr),
    .zero        (zero),
    .jr_target   (jr_target),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Overall time limit, so that the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Reference next-PC rule computed with plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc,
      input logic [31:0] iw, input logic b, input logic n, input logic j,
      input logic r, input logic z, input logic [31:0] jt);
    logic [31:0] p4;
    logic [31:0] tgt;
    int          off;
    p4 = cur_pc + 32'd4;
    if (r) begin
      tgt = jt;
    end else if (j) begin
      tgt = (p4 & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
    end else if (b && (z != n)) begin
      off = int'($signed(iw[15:0]));
      tgt = p4 + 32'(off * 4);
    end else begin
      tgt = p4;
    end
`ifndef FETCH_MISALIGN_TRAP_EN
    tgt = tgt & 32'hFFFF_FFFC;
`endif
    return tgt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    retire = 1'b0;
    tick();
    reset = 1'b0;
    m_pc = RST_PC;
  endtask

  task automatic fetch_word(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_retire(input logic b, input logic n, input logic j,
      input logic r, input logic z, input logic [31:0] jt);
    branch = b; ne = n; jump = j; jr = r; zero = z; jr_target = jt;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    branch = 1'($urandom); ne = 1'($urandom); jump = 1'($urandom);
    jr = 1'($urandom); zero = 1'($urandom); jr_target = $urandom;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
    n_cmp++; if (pc_plus4 !== RST_PC + 32'd4) begin n_bad++; $display("[TB] FAIL reset_pc4: got %h expected %h", pc_plus4, RST_PC + 32'd4); end
    n_cmp++; if (instr !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fault: got %b expected 0", fetch_fault); end
  endtask

  task automatic test_zero_wait();
    // A retire while no instruction is valid must be ignored.
    jr = 1'b1; jr_target = 32'h0000_1234; retire = 1'b1;
    tick();
    retire = 1'b0;
    n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("[TB] FAIL early_retire_pc: got %h expected %h", pc, RST_PC); end
    fetch_word(32'h2008_0005, 0);
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL zw_valid: got %b expected 1", instr_valid); end
    n_cmp++; if (instr !== 32'h2008_0005) begin n_bad++; $display("[TB] FAIL zw_instr: got %h expected 20080005", instr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL zw_req_low: got %b expected 0", imem_req); end
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_pc = RST_PC + 32'd4;
    n_cmp++; if (pc !== m_pc) begin n_bad++; $display("[TB] FAIL zw_seq_pc: got %h expected %h", pc, m_pc); end
    n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL zw_refetch: got valid=%b req=%b expected valid=0 req=1", instr_valid, imem_req); end
  endtask

  task automatic test_wait_states();
    logic [31:0] word;
    word = $urandom;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ws_stall_%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", i, imem_req, imem_addr, instr_valid, m_pc); end
      imem_ack = (i == 3);
      imem_rdata = (i == 3) ? word : $urandom;
      tick();
    end
    // A late or duplicate ack must not overwrite the captured word.
    imem_ack = 1'b1;
    imem_rdata = ~word;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== word) begin n_bad++; $display("[TB] FAIL ws_capture: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, word); end
    tick();
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (instr !== word || instr_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ws_no_dup: got valid=%b instr=%h expected valid=1 instr=%h", instr_valid, instr, word); end
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_pc = m_pc + 32'd4;
    n_cmp++; if (pc !== m_pc) begin n_bad++; $display("[TB] FAIL ws_pc: got %h expected %h", pc, m_pc); end
  endtask

  task automatic test_branch();
    fetch_word($urandom, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    fetch_word(32'h1000_FFFF, 1);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    n_cmp++; if (pc !== 32'h0000_0100) begin n_bad++; $display("[TB] FAIL beq_taken: got %h expected 00000100", pc); end
    fetch_word(32'h1000_FFFF, 0);
    do_retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    n_cmp++; if (pc !== 32'h0000_0104) begin n_bad++; $display("[TB] FAIL bne_not_taken: got %h expected 00000104", pc); end
    n_cmp++; if (pc_plus4 !== 32'h0000_0108) begin n_bad++; $display("[TB] FAIL bne_pc4: got %h expected 00000108", pc_plus4); end
    m_pc = 32'h0000_0104;
  endtask

  task automatic test_priority();
    fetch_word($urandom, 2);
    do_retire(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
    n_cmp++; if (pc !== 32'h0000_2000) begin n_bad++; $display("[TB] FAIL jr_wins: got %h expected 00002000", pc); end
    fetch_word($urandom, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000);
    fetch_word(32'h0810_0000, 0);
    do_retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, $urandom);
    n_cmp++; if (pc !== 32'h1040_0000) begin n_bad++; $display("[TB] FAIL jump_target: got %h expected 10400000", pc); end
    m_pc = 32'h1040_0000;
  endtask

  task automatic test_wrap();
    fetch_word($urandom, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    n_cmp++; if (pc_plus4 !== 32'd0) begin n_bad++; $display("[TB] FAIL wrap_pc4: got %h expected 00000000", pc_plus4); end
    fetch_word($urandom, 1);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    n_cmp++; if (pc !== 32'd0 || fetch_fault !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_pc: got pc=%h fault=%b expected pc=0 fault=0", pc, fetch_fault); end
    m_pc = 32'd0;
  endtask

  task automatic test_reset_mid_req();
    fetch_word(32'h1234_5678, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // The design is now in S_REQ. Assert reset with an ack in the same cycle.
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    imem_ack = 1'b0;
    m_pc = RST_PC;
    n_cmp++; if (instr !== 32'd0 || instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_instr: got instr=%h valid=%b expected 0/0", instr, instr_valid); end
    n_cmp++; if (pc !== RST_PC || imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_pc: got pc=%h req=%b expected %h/1", pc, imem_req, RST_PC); end
    tick();
    n_cmp++; if (instr !== 32'd0 || instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_nocap: got instr=%h valid=%b expected 0/0", instr, instr_valid); end
  endtask

  task automatic test_random();
    logic [31:0] word;
    logic [31:0] exp;
    logic [31:0] jt;
    logic        b, n, j, r, z;
    for (int it = 0; it < 40; it++) begin
      word = $urandom;
      fetch_word(word, $urandom_range(0, 3));
      n_cmp++; if (instr !== word || instr_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL rnd_fetch_%0d: got instr=%h valid=%b expected %h/1", it, instr, instr_valid, word); end
      b = 1'($urandom); n = 1'($urandom); j = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) == 0); z = 1'($urandom);
      jt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      jt = jt & 32'hFFFF_FFFC;
`endif
      exp = model_next(m_pc, word, b, n, j, r, z, jt);
      do_retire(b, n, j, r, z, jt);
      n_cmp++; if (pc !== exp || pc_plus4 !== exp + 32'd4 || imem_addr !== exp) begin n_bad++; $display("[TB] FAIL rnd_pc_%0d: got pc=%h pc4=%h addr=%h expected pc=%h", it, pc, pc_plus4, imem_addr, exp); end
      m_pc = exp;
    end
  endtask

  task automatic test_misalign();
    fetch_word($urandom, 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2002);
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0000_2002) begin n_bad++; $display("[TB] FAIL trap_enter: got fault=%b req=%b pc=%h expected 1/0/00002002", fetch_fault, imem_req, pc); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; retire = 1'b1;
      tick();
    end
    imem_ack = 1'b0; retire = 1'b0;
    n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL trap_hold: got fault=%b req=%b valid=%b expected 1/0/0", fetch_fault, imem_req, instr_valid); end
    apply_reset();
    n_cmp++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL trap_exit: got fault=%b req=%b expected 0/1", fetch_fault, imem_req); end
`else
    n_cmp++; if (pc !== 32'h0000_2000 || fetch_fault !== 1'b0) begin n_bad++; $display("[TB] FAIL misalign_mask: got pc=%h fault=%b expected 00002000/0", pc, fetch_fault); end
`endif
  endtask

  initial begin
    $display("[TB] fetch_unit bench start");
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_priority();
    test_wrap();
    test_reset_mid_req();
    test_random();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
